// File: rtl/pea_pkg.sv
// Shared definitions for the PEA invoke controller: opcodes, next-mode
// encodings, FSM states, command word field positions and a log2 helper.
package pea_pkg;

    localparam logic [2:0] OP_STP = 3'd0;
    localparam logic [2:0] OP_EVP = 3'd1;
    localparam logic [2:0] OP_EVB = 3'd2;
    localparam logic [2:0] OP_RST = 3'd3;

    localparam logic [1:0] SETUP_INSTR = 2'b00;
    localparam logic [1:0] INSTR       = 2'b01;

    // Command word: [2:0] opcode, [7:3] arg2, [10:8] arg1, upper bits reserved
    localparam int CMD_OPC_LSB  = 0;
    localparam int CMD_ARG2_LSB = 3;
    localparam int CMD_ARG1_LSB = 8;
    localparam int CMD_RSVD_LSB = 11;

    typedef enum logic [2:0] {
        ST_SETUP  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FIRE   = 3'd4,
        ST_WAIT   = 3'd5
    } pea_state_e;

    // Ceiling log2, used to size FIFO pointers from the buffer depth
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_resource_check.sv
// Combinational resource gate: data FIFO occupancy (modulo pointer
// difference) compared against what the latched mode needs.
module pea_resource_check
    import pea_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] dat_wr_addr,
    input  logic [ADDR_W-1:0] dat_rd_addr,
    input  logic [ADDR_W-1:0] result_free_space,
    input  logic [ADDR_W-1:0] status_free_space,
    input  logic [2:0]        mode,
    input  logic [4:0]        arg2,
    output logic              ready
);

    logic [ADDR_W-1:0] dat_occ;
    logic [ADDR_W-1:0] arg2_ext;

    // Pointer subtraction wraps naturally at ADDR_W bits
    assign dat_occ  = dat_wr_addr - dat_rd_addr;
    assign arg2_ext = ADDR_W'(arg2);

    // Per-mode enable condition
    always_comb begin
        ready = 1'b0;
        case (mode)
            OP_STP:  ready = (dat_occ >= arg2_ext) && (result_free_space != '0);
            OP_EVP:  ready = (dat_occ != '0) && (result_free_space != '0)
                             && (status_free_space != '0);
            OP_EVB:  ready = (dat_occ >= arg2_ext) && (result_free_space >= arg2_ext)
                             && (status_free_space >= arg2_ext);
            OP_RST:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: rtl/pea_invoke_ctrl.sv
// Invoke FSM for the PEA core: pops a command, validates it, waits for
// FIFO resources, fires a one-cycle start and waits for done.
// Optional watchdog on the WAIT state: define PEA_WATCHDOG_EN.
//
// state  | meaning
// SETUP  | idle, waiting for a command word
// FETCH  | pop command, latch opcode/arg1/arg2
// DECODE | validate latched command, drop if invalid
// CHECK  | wait until data/result/status FIFOs allow the mode
// FIRE   | one-cycle core_start
// WAIT   | wait for core_done (or watchdog expiry)
module pea_invoke_ctrl
    import pea_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024,
    parameter int WD_CYCLES   = 65535,
    localparam int ADDR_W     = log2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    cmd_wr_addr,
    input  logic [ADDR_W-1:0]    cmd_rd_addr,
    input  logic [word_size-1:0] cmd_data,
    output logic                 cmd_rd_en,
    input  logic [ADDR_W-1:0]    dat_wr_addr,
    input  logic [ADDR_W-1:0]    dat_rd_addr,
    input  logic [ADDR_W-1:0]    result_free_space,
    input  logic [ADDR_W-1:0]    status_free_space,
    output logic                 core_start,
    output logic [7:0]           core_mode,
    output logic [2:0]           core_arg1,
    output logic [4:0]           core_arg2,
    input  logic                 core_done,
    output logic [1:0]           next_mode_out,
    output logic                 busy,
    output logic                 err_invalid,
    output logic                 err_timeout
);

    pea_state_e        state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [2:0]        arg1_q, arg1_d;
    logic [4:0]        arg2_q, arg2_d;
    logic [ADDR_W-1:0] cmd_occ;
    logic              res_ready;
    logic              cmd_invalid;
    logic              unused_rsvd;

`ifdef PEA_WATCHDOG_EN
    logic [15:0]       wd_q, wd_d;
`else
    logic [15:0]       unused_wd_limit;
    assign unused_wd_limit = 16'(WD_CYCLES);
    assign err_timeout     = 1'b0;
`endif

    assign cmd_occ     = cmd_wr_addr - cmd_rd_addr;
    assign unused_rsvd = ^cmd_data[word_size-1:CMD_RSVD_LSB];
    assign cmd_invalid = mode_q[2]
                         || (((mode_q == OP_STP) || (mode_q == OP_EVB)) && (arg2_q == '0));

    assign core_mode = {5'b0, mode_q};
    assign core_arg1 = arg1_q;
    assign core_arg2 = arg2_q;

    pea_resource_check #(.ADDR_W(ADDR_W)) u_res_check (
        .dat_wr_addr       (dat_wr_addr),
        .dat_rd_addr       (dat_rd_addr),
        .result_free_space (result_free_space),
        .status_free_space (status_free_space),
        .mode              (mode_q),
        .arg2              (arg2_q),
        .ready             (res_ready)
    );

    // State, latched command fields and watchdog counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SETUP;
            mode_q  <= '0;
            arg1_q  <= '0;
            arg2_q  <= '0;
`ifdef PEA_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            arg1_q  <= arg1_d;
            arg2_q  <= arg2_d;
`ifdef PEA_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Next-state logic and Moore-style outputs
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        arg1_d        = arg1_q;
        arg2_d        = arg2_q;
        cmd_rd_en     = 1'b0;
        core_start    = 1'b0;
        busy          = 1'b1;
        next_mode_out = INSTR;
        err_invalid   = 1'b0;
`ifdef PEA_WATCHDOG_EN
        wd_d          = wd_q;
        err_timeout   = 1'b0;
`endif
        case (state_q)
            ST_SETUP: begin
                busy          = 1'b0;
                next_mode_out = SETUP_INSTR;
                if (cmd_occ != '0) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                next_mode_out = SETUP_INSTR;
                cmd_rd_en     = 1'b1;
                mode_d        = cmd_data[CMD_OPC_LSB +: 3];
                arg2_d        = cmd_data[CMD_ARG2_LSB +: 5];
                arg1_d        = cmd_data[CMD_ARG1_LSB +: 3];
                state_d       = ST_DECODE;
            end
            ST_DECODE: begin
                if (cmd_invalid) begin
                    err_invalid = 1'b1;
                    state_d     = ST_SETUP;
                end else begin
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (res_ready) state_d = ST_FIRE;
            end
            ST_FIRE: begin
                core_start = 1'b1;
                state_d    = ST_WAIT;
`ifdef PEA_WATCHDOG_EN
                wd_d       = '0;
`endif
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_SETUP;
`ifdef PEA_WATCHDOG_EN
                end else if (wd_q == 16'(WD_CYCLES)) begin
                    err_timeout = 1'b1;
                    state_d     = ST_SETUP;
                end else begin
                    wd_d = wd_q + 16'd1;
`endif
                end
            end
            default: state_d = ST_SETUP;
        endcase
    end

endmodule

// File: tb/tb_pea_invoke_ctrl.sv
// Self-checking bench for pea_invoke_ctrl. Each command is run over a fixed
// 32-cycle window; a transaction-level model predicts the cycle of every
// pop/start/error pulse and the busy/next-mode envelope from the command
// rules, and the observed per-cycle bit vectors are compared against it.
module tb_pea_invoke_ctrl;

    localparam int WD = 16;
    localparam int NC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cmd_wr_addr, cmd_rd_addr;
    logic [15:0] cmd_data;
    logic        cmd_rd_en;
    logic [9:0]  dat_wr_addr, dat_rd_addr;
    logic [9:0]  result_free_space, status_free_space;
    logic        core_start;
    logic [7:0]  core_mode;
    logic [2:0]  core_arg1;
    logic [4:0]  core_arg2;
    logic        core_done;
    logic [1:0]  next_mode_out;
    logic        busy, err_invalid, err_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pea_invoke_ctrl #(.word_size(16), .buffer_size(1024), .WD_CYCLES(WD)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_wr_addr       (cmd_wr_addr),
        .cmd_rd_addr       (cmd_rd_addr),
        .cmd_data          (cmd_data),
        .cmd_rd_en         (cmd_rd_en),
        .dat_wr_addr       (dat_wr_addr),
        .dat_rd_addr       (dat_rd_addr),
        .result_free_space (result_free_space),
        .status_free_space (status_free_space),
        .core_start        (core_start),
        .core_mode         (core_mode),
        .core_arg1         (core_arg1),
        .core_arg2         (core_arg2),
        .core_done         (core_done),
        .next_mode_out     (next_mode_out),
        .busy              (busy),
        .err_invalid       (err_invalid),
        .err_timeout       (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // occ: data occupancy, drd: data read pointer (write = drd+occ mod 1024),
    // dly: cycles from start to done, dfire: extra done during FIRE,
    // rst_at: cycle at which a two-cycle reset begins (-1 = none)
    task automatic run_cmd(input string tag, input logic [15:0] word, input int occ,
                           input int drd, input int rfs, input int sfs, input int dly,
                           input bit dfire, input int rst_at);
        int op, a1, a2, nd, nr, ns, s, e, to_c, fix_c;
        bit valid, ready0, pend_pop;
        logic [31:0] ev_pop, ev_start, ev_inv, ev_busy, ev_nm, ev_to;
        logic [31:0] ob_pop, ob_start, ob_inv, ob_busy, ob_nm, ob_to;
        logic [7:0] mode_at;
        logic [2:0] a1_at;
        logic [4:0] a2_at;

        op = int'(word[2:0]);
        a2 = int'(word[7:3]);
        a1 = int'(word[10:8]);
        valid = (op < 4) && !(((op == 0) || (op == 2)) && (a2 == 0));
        case (op)
            0:       begin nd = a2; nr = 1;  ns = 0;  end
            1:       begin nd = 1;  nr = 1;  ns = 1;  end
            2:       begin nd = a2; nr = a2; ns = a2; end
            default: begin nd = 0;  nr = 0;  ns = 0;  end
        endcase
        ready0 = (occ >= nd) && (rfs >= nr) && (sfs >= ns);
        fix_c  = 9;
        to_c   = -1;
        if (valid) begin
            s = ready0 ? 4 : fix_c + 1;
            e = s + dly;
`ifdef PEA_WATCHDOG_EN
            if (dly > WD + 1) begin
                e    = s + 1 + WD;
                to_c = e;
            end
`endif
        end else begin
            s = -1;
            e = 2;
        end
        if (rst_at >= 0 && rst_at < e) e = rst_at;
        if (rst_at >= 0 && to_c > rst_at) to_c = -1;

        ev_pop   = 32'd1 << 1;
        ev_start = (s >= 0) ? (32'd1 << s) : 32'd0;
        ev_inv   = valid ? 32'd0 : (32'd1 << 2);
        ev_to    = (to_c >= 0) ? (32'd1 << to_c) : 32'd0;
        ev_busy  = '0;
        ev_nm    = '0;
        for (int c = 1; c < NC && c <= e; c++) ev_busy[c] = 1'b1;
        for (int c = 2; c < NC && c <= e; c++) ev_nm[c] = 1'b1;

        ob_pop = '0; ob_start = '0; ob_inv = '0; ob_busy = '0; ob_nm = '0; ob_to = '0;
        mode_at = 'x; a1_at = 'x; a2_at = 'x;
        pend_pop = 1'b0;

        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                cmd_data          = word;
                cmd_wr_addr       = cmd_rd_addr + 10'd1;
                dat_rd_addr       = 10'(drd);
                dat_wr_addr       = 10'(drd + occ);
                result_free_space = 10'(rfs);
                status_free_space = 10'(sfs);
            end
            if (pend_pop) cmd_rd_addr = cmd_rd_addr + 10'd1;
            if (c == fix_c && !ready0) begin
                dat_rd_addr       = dat_wr_addr - 10'(imax(occ, nd));
                result_free_space = 10'(imax(rfs, nr));
                status_free_space = 10'(imax(sfs, ns));
            end
            core_done = valid && ((c == s + dly) || (dfire && c == s));
            rst = !(rst_at >= 0 && (c == rst_at || c == rst_at + 1));
            #1;
            ob_pop[c]   = cmd_rd_en;
            ob_start[c] = core_start;
            ob_inv[c]   = err_invalid;
            ob_busy[c]  = busy;
            ob_nm[c]    = (next_mode_out == 2'b01);
            ob_to[c]    = err_timeout;
            pend_pop    = cmd_rd_en;
            if (next_mode_out != 2'b00 && next_mode_out != 2'b01) ob_nm[c] = 1'bx;
            if (core_start) begin
                mode_at = core_mode;
                a1_at   = core_arg1;
                a2_at   = core_arg2;
            end
        end
        core_done = 1'b0;
        rst       = 1'b1;

        check({tag, " pop"},     ob_pop,   ev_pop);
        check({tag, " start"},   ob_start, ev_start);
        check({tag, " invalid"}, ob_inv,   ev_inv);
        check({tag, " busy"},    ob_busy,  ev_busy);
        check({tag, " nextmode"}, ob_nm,   ev_nm);
        check({tag, " timeout"}, ob_to,    ev_to);
        if (valid) begin
            check({tag, " mode"}, 32'(mode_at), 32'(op));
            check({tag, " arg1"}, 32'(a1_at),   32'(a1));
            check({tag, " arg2"}, 32'(a2_at),   32'(a2));
        end
        if (rst_at >= 0) begin
            check({tag, " rst_mode"}, {24'd0, core_mode}, 32'd0);
            check({tag, " rst_args"}, {24'd0, core_arg1, core_arg2}, 32'd0);
        end
    endtask

    initial begin
        rst               = 1'b0;
        cmd_wr_addr       = '0;
        cmd_rd_addr       = '0;
        cmd_data          = '0;
        dat_wr_addr       = '0;
        dat_rd_addr       = '0;
        result_free_space = '0;
        status_free_space = '0;
        core_done         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("init outs", {28'd0, cmd_rd_en, core_start, busy, err_invalid},  32'd0);
        check("init mode", {22'd0, core_mode, next_mode_out}, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", {30'd0, busy, cmd_rd_en}, 32'd0);

        // Directed cases
        run_cmd("evp",       16'h0001, 1, 100, 5, 5, 3, 1'b0, -1);
        run_cmd("evp_dfire", 16'h0001, 1, 512, 5, 5, 3, 1'b1, -1);
        run_cmd("evb_hold",  16'h0042, 7, 200, 10, 10, 2, 1'b0, -1);
        run_cmd("stp_wrap",  16'h0038, 7, 1020, 1, 0, 2, 1'b0, -1);
        run_cmd("stp_short", 16'h0038, 6, 1021, 1, 0, 2, 1'b0, -1);
        run_cmd("inv_op5",   16'h0005, 9, 0, 9, 9, 2, 1'b0, -1);
        run_cmd("inv_stp0",  16'h0000, 9, 0, 9, 9, 2, 1'b0, -1);
        run_cmd("rst_cmd",   16'h0003, 0, 0, 0, 0, 1, 1'b0, -1);
        run_cmd("evp_nofs",  16'h0001, 3, 7, 0, 4, 2, 1'b0, -1);
        run_cmd("rsvd_bits", 16'hF9A1, 2, 33, 1, 1, 4, 1'b0, -1);
        run_cmd("reset_mid", 16'h0001, 1, 0, 5, 5, 100, 1'b0, 7);
        run_cmd("long_wait", 16'h0001, 1, 0, 5, 5, 100, 1'b0, 28);

        // Randomized commands and resource levels
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[7:3] = 5'd0;
            run_cmd("rand", w, int'($urandom_range(0, 36)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 36)), int'($urandom_range(0, 36)),
                    int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
